// File: rtl/fuzzy_mmio_host_if.sv
// fuzzy_mmio_host_if: 8-bit MMIO bus between the host initiator and the fuzzy controller slave.
interface fuzzy_mmio_host_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       status_valid;
    modport master(output cs, rd, wr, addr, wdata, input rdata, status_valid);
    modport slave(input cs, rd, wr, addr, wdata, output rdata, status_valid);
endinterface

// File: rtl/fuzzy_mmio_host.sv
// fuzzy_mmio_host: runs one T/dT/CTRL write, completion wait and G_out read per start pulse.
// Define FUZZY_MMIO_HOST_POLL_EN to detect completion by polling STATUS instead of status_valid.
module fuzzy_mmio_host #(
    parameter int         TIMEOUT_CYC = 255,
    parameter logic [7:0] ADDR_STATUS = 8'h00,
    parameter logic [7:0] ADDR_CTRL   = 8'h01,
    parameter logic [7:0] ADDR_T      = 8'h02,
    parameter logic [7:0] ADDR_DT     = 8'h03,
    parameter logic [7:0] ADDR_GOUT   = 8'h04
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        t_in,
    input  logic [7:0]        dt_in,
    input  logic              reg_mode,
    input  logic              dt_mode,
    output logic              busy,
    output logic              done,
    output logic [7:0]        g_out,
    output logic              timeout_err,
    fuzzy_mmio_host_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, WR_T, GAP_T, WR_DT, GAP_DT, WR_CTRL, GAP_CTRL,
        WAIT_DONE, POLL1, POLL2, RD_G1, RD_G2
    } state_t;
    localparam logic [16:0] TMO = 17'(TIMEOUT_CYC);
    state_t      state, nxt;
    logic [7:0]  t_q, dt_q;
    logic        reg_mode_q, dt_mode_q, accept, abort, tmo;
    logic [16:0] cnt;
    assign accept = state == IDLE && start;
    assign abort  = state == WAIT_DONE && nxt == IDLE;
    assign tmo    = cnt + 17'd1 >= TMO;
    assign busy   = state != IDLE;
`ifdef FUZZY_MMIO_HOST_POLL_EN
    logic stat_busy;
    // Assume the slave is busy until a STATUS read proves otherwise.
    always_ff @(posedge clk or posedge rst)
        if (rst) stat_busy <= 1'b1;
        else if (accept) stat_busy <= 1'b1;
        else if (state == POLL2) stat_busy <= bus.rdata[0];
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start ? WR_T : IDLE;
            WR_T:      nxt = GAP_T;
            GAP_T:     nxt = dt_mode_q ? WR_CTRL : WR_DT;
            WR_DT:     nxt = GAP_DT;
            GAP_DT:    nxt = WR_CTRL;
            WR_CTRL:   nxt = GAP_CTRL;
`ifdef FUZZY_MMIO_HOST_POLL_EN
            GAP_CTRL:  nxt = WAIT_DONE;
            WAIT_DONE: nxt = !stat_busy ? RD_G1 : tmo ? IDLE : POLL1;
            POLL1:     nxt = POLL2;
            POLL2:     nxt = WAIT_DONE;
`else
            GAP_CTRL:  nxt = bus.status_valid ? RD_G1 : WAIT_DONE;
            WAIT_DONE: nxt = bus.status_valid ? RD_G1 : tmo ? IDLE : WAIT_DONE;
`endif
            RD_G1:     nxt = RD_G2;
            RD_G2:     nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end
    // Bus is decoded straight from state so reset drops strobes without waiting for an edge.
    always_comb begin
        bus.wr    = state inside {WR_T, WR_DT, WR_CTRL};
        bus.rd    = state inside {POLL1, POLL2, RD_G1, RD_G2};
        bus.cs    = bus.wr | bus.rd;
        bus.addr  = state == WR_T ? ADDR_T :
                    state == WR_DT ? ADDR_DT :
                    state == WR_CTRL ? ADDR_CTRL :
                    state inside {POLL1, POLL2} ? ADDR_STATUS :
                    state inside {RD_G1, RD_G2} ? ADDR_GOUT : 8'h00;
        bus.wdata = state == WR_T ? t_q :
                    state == WR_DT ? dt_q :
                    state == WR_CTRL ? {5'b0, dt_mode_q, reg_mode_q, 1'b1} : 8'h00;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            t_q         <= 8'h00;
            dt_q        <= 8'h00;
            reg_mode_q  <= 1'b0;
            dt_mode_q   <= 1'b0;
            done        <= 1'b0;
            g_out       <= 8'h00;
            timeout_err <= 1'b0;
            cnt         <= '0;
        end else begin
            state <= nxt;
            done  <= state == RD_G2 || abort;
            if (accept) begin
                t_q         <= t_in;
                dt_q        <= dt_in;
                reg_mode_q  <= reg_mode;
                dt_mode_q   <= dt_mode;
                timeout_err <= 1'b0;
            end else if (abort) timeout_err <= 1'b1;
            if (state == RD_G2) g_out <= bus.rdata;
            // Zero during the CTRL write, then count every cycle spent waiting.
            cnt <= nxt == WR_CTRL ? '0 :
                   state inside {WR_CTRL, GAP_CTRL, WAIT_DONE, POLL1, POLL2} ? cnt + 17'd1 : cnt;
        end
endmodule

// File: tb/tb_fuzzy_mmio_host.sv
// tb_fuzzy_mmio_host: scoreboard bench with a behavioural MMIO slave and cycle-exact expected bus traffic.
module tb_fuzzy_mmio_host;
    localparam int TMO = 20;
    logic       clk = 0, rst = 0, start = 0, reg_mode = 0, dt_mode = 0;
    logic [7:0] t_in = 0, dt_in = 0, g_out;
    logic       busy, done, timeout_err;
    fuzzy_mmio_host_if bus();
    fuzzy_mmio_host #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .t_in(t_in), .dt_in(dt_in),
        .reg_mode(reg_mode), .dt_mode(dt_mode), .busy(busy), .done(done),
        .g_out(g_out), .timeout_err(timeout_err), .bus(bus)
    );
    always #5 clk = ~clk;

    typedef struct {int cyc; bit w; logic [7:0] addr; logic [7:0] data;} bus_ev_t;
    typedef struct {int cyc; logic [7:0] g; bit terr; int busy_n;} done_ev_t;
    bus_ev_t    bq[$];
    done_ev_t   dq[$];
    int         errors = 0, checks = 0, cyc = 0, busy_n = 0;
    int         sv_delay = 2, busy_len = 6, ctrl_cyc = -1000;
    bit         mon_en = 0;
    logic [7:0] gval = 8'd50, g_model = 8'd0;

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, cyc);
        end
    endtask

    // Behavioural slave: sideband pulse sv_delay cycles after CTRL, STATUS busy for busy_len cycles.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (bus.cs && bus.wr && bus.addr == 8'h01) ctrl_cyc = cyc;
        bus.status_valid = sv_delay >= 0 && cyc == ctrl_cyc + sv_delay;
        bus.rdata = bus.addr == 8'h04 ? gval :
                    bus.addr == 8'h00 ? {7'b0, cyc > ctrl_cyc && cyc <= ctrl_cyc + busy_len} : 8'h00;
    end

    always @(negedge clk) if (mon_en) begin : mon
        bus_ev_t  e;
        done_ev_t d;
        if (busy) busy_n++;
        if (bus.cs) begin
            if (bq.size() == 0) chk("bus_unexpected_addr", bus.addr, -1);
            else begin
                e = bq.pop_front();
                chk("bus_cyc", cyc, e.cyc);
                chk("bus_wr", bus.wr, e.w);
                chk("bus_rd", bus.rd, !e.w);
                chk("bus_addr", bus.addr, e.addr);
                if (e.w) chk("bus_wdata", bus.wdata, e.data);
            end
        end else chk("idle_bus", {bus.rd, bus.wr, bus.addr, bus.wdata}, 0);
        if (done) begin
            if (dq.size() == 0) chk("done_unexpected", done, 0);
            else begin
                d = dq.pop_front();
                chk("done_cyc", cyc, d.cyc);
                chk("g_out", g_out, d.g);
                chk("timeout_err", timeout_err, d.terr);
                chk("busy_cycles", busy_n, d.busy_n);
                chk("busy_at_done", busy, 0);
            end
            busy_n = 0;
        end
    end

    task automatic expect_txn(int s, logic [7:0] t, logic [7:0] dt, bit rm, bit dm, output int dn);
        int c, k, rd_at;
`ifdef FUZZY_MMIO_HOST_POLL_EN
        bit pbusy;
`endif
        c = s + (dm ? 3 : 5);
        rd_at = -1;
        bq.push_back('{s + 1, 1'b1, 8'h02, t});
        if (!dm) bq.push_back('{s + 3, 1'b1, 8'h03, dt});
        bq.push_back('{c, 1'b1, 8'h01, {5'b0, dm, rm, 1'b1}});
`ifdef FUZZY_MMIO_HOST_POLL_EN
        pbusy = 1;
        for (k = c + 2; k < c + 70000; k += 3) begin
            if (!pbusy) begin rd_at = k + 1; break; end
            if (k - c + 1 >= TMO) break;
            bq.push_back('{k + 1, 1'b0, 8'h00, 8'h00});
            bq.push_back('{k + 2, 1'b0, 8'h00, 8'h00});
            pbusy = k + 2 <= c + busy_len;
        end
`else
        for (k = c + 1; k < c + 70000; k++) begin
            if (sv_delay >= 0 && k == c + sv_delay) begin rd_at = k + 1; break; end
            if (k >= c + 2 && k - c + 1 >= TMO) break;
        end
`endif
        if (rd_at >= 0) begin
            bq.push_back('{rd_at, 1'b0, 8'h04, 8'h00});
            bq.push_back('{rd_at + 1, 1'b0, 8'h04, 8'h00});
            g_model = gval;
            dn = rd_at + 2;
            dq.push_back('{dn, g_model, 1'b0, dn - s - 1});
        end else begin
            dn = k + 1;
            dq.push_back('{dn, g_model, 1'b1, k - s});
        end
    endtask

    task automatic run(logic [7:0] t, logic [7:0] dt, bit rm, bit dm, int svd, int blen, output int dn);
        sv_delay = svd;
        busy_len = blen;
        expect_txn(cyc, t, dt, rm, dm, dn);
        t_in = t; dt_in = dt; reg_mode = rm; dt_mode = dm; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic to_cycle(int n);
        while (cyc < n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int d, s;
        bus.rdata = 8'h00;
        bus.status_valid = 0;
        #1 rst = 1;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_g_out", g_out, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_cs", bus.cs, 0);
        #8 rst = 0;
        @(posedge clk); #1;
        mon_en = 1;
        run(8'd32, 8'd32, 1, 0, 2, 6, d);
        to_cycle(d + 2);
        gval = 8'd77;
        run(8'd10, 8'd99, 0, 1, 2, 6, d);
        to_cycle(d + 2);
        gval = 8'd91;
        run(8'd5, 8'd6, 0, 0, 3, 6, d);
        to_cycle(d - 4);
        t_in = 8'hEE; start = 1;
        @(posedge clk); #1;
        start = 0;
        to_cycle(d);
        gval = 8'd120;
        run(8'd7, 8'hF9, 1, 0, 2, 6, d);
        to_cycle(d + 2);
        gval = 8'd13;
        run(8'd1, 8'd2, 0, 0, -1, 1000, d);
        to_cycle(d + 3);
        run(8'd3, 8'd4, 0, 0, 2, 6, d);
        chk("terr_cleared", timeout_err, 0);
        to_cycle(d + 3);
        chk("bus_queue_drained", bq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        mon_en = 0;
        s = cyc;
        t_in = 8'd9; dt_mode = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        to_cycle(s + 5);
        chk("ctrl_wr_before_rst", bus.wr, 1);
        #1 rst = 1;
        #1;
        chk("midrst_cs", bus.cs, 0);
        chk("midrst_rd", bus.rd, 0);
        chk("midrst_wr", bus.wr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_g_out", g_out, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        #3 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle_cs", bus.cs, 0);
        chk("post_rst_idle_busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fuzzy_mmio_host.md
Name: fuzzy_mmio_host

Overview:
- Bus initiator that drives the fuzzy controller's 8-bit MMIO slave interface (cs/rd/wr/addr/wdata/rdata) from a simple local command port.
- On one start pulse it performs a full inference transaction:
  - write T, then dT;
  - write CTRL with START set;
  - wait for completion;
  - read G_out.
- Sits between a local host (sensor sampler / CPU shim) and the controller top. MF and singleton configuration is out of scope.

Parameters:
- TIMEOUT_CYC, 255, cycles allowed from the CTRL write until completion before aborting (1..65535).
- ADDR_STATUS, 8'h00, STATUS register address.
- ADDR_CTRL, 8'h01, CTRL register address.
- ADDR_T, 8'h02, T input register address.
- ADDR_DT, 8'h03, dT input register address.
- ADDR_GOUT, 8'h04, G_out result register address.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; ignored while busy=1
- t_in  in  8  signed T sample, latched on accepted start
- dt_in  in  8  signed external dT, latched on accepted start
- reg_mode  in  1  CTRL[1] value, latched on accepted start
- dt_mode  in  1  CTRL[2] value, latched on accepted start; 1 = internal dT
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- g_out  out  8  last G_out read; holds until next successful read
- timeout_err  out  1  sticky abort flag; cleared on next accepted start
- cs  out  1  MMIO chip select
- rd  out  1  MMIO read strobe
- wr  out  1  MMIO write strobe
- addr  out  8  MMIO address
- wdata  out  8  MMIO write data
- rdata  in  8  MMIO read data
- status_valid  in  1  completion sideband from the slave (one-cycle pulse)

Behaviour:
- Reset (asynchronous, active-high):
  - every output = 0;
  - FSM = IDLE;
  - latched operands = 0;
  - timeout counter = 0.
  - Assertion mid-transaction drops cs/rd/wr immediately and aborts with no done pulse.
- Bus cycle rules:
  - Write = 1 cycle with cs=wr=1 and addr/wdata valid.
  - Read = 2 cycles with cs=rd=1 and addr held; rdata is captured at the rising edge ending the 2nd cycle.
  - Every write or read is followed by exactly 1 idle cycle: cs=rd=wr=0, addr=0, wdata=0.
  - rd and wr are never asserted together.
- FSM states: IDLE, WR_T, WR_DT, WR_CTRL, WAIT_DONE, RD_G1, RD_G2, plus a GAP cycle after each bus op.
- IDLE:
  - start=1 is accepted.
  - Operands and modes are latched, busy=1 from the next cycle, timeout_err is cleared.
  - Next state is WR_T.
- WR_T: write ADDR_T = latched T.
- WR_DT: write ADDR_DT = latched dT. Skipped entirely (no bus cycle, no gap) when dt_mode=1.
- WR_CTRL:
  - write ADDR_CTRL = {4'b0, 1'b0, dt_mode, reg_mode, 1'b1};
  - INIT is always 0;
  - the timeout counter clears in this cycle.
- WAIT_DONE:
  - Counter increments each cycle.
  - Exit on status_valid=1, then go to RD_G1.
  - When the counter reaches TIMEOUT_CYC, go to IDLE with timeout_err=1, done=1 for one cycle, and g_out unchanged.
  - If status_valid and timeout occur in the same cycle, status_valid wins.
- RD_G1/RD_G2:
  - read ADDR_GOUT;
  - g_out is updated at the end of RD_G2;
  - after the gap cycle, done=1 for one cycle and busy=0 in the same cycle.
  - Next state is IDLE.
- start asserted while busy=1 is dropped (no queueing).
- start in the cycle done=1: the FSM is already IDLE, so start is accepted.
- Latency, dt_mode=0, slave valid 2 cycles after CTRL write, start accepted at edge 0:
  - T write cycle 1, dT write cycle 3, CTRL write cycle 5;
  - status_valid observed in cycle 7;
  - read cycles 8–9, gap cycle 10;
  - done asserted in cycle 10, busy=0.

Optional Feature:
- Macro FUZZY_MMIO_HOST_POLL_EN.
- Defined: WAIT_DONE ignores status_valid.
  - Instead it issues repeated 2-cycle STATUS reads of ADDR_STATUS, each followed by a gap cycle.
  - Completion = the first captured STATUS with bit0 (busy) = 0.
  - The slave raises busy the cycle after the START write, so the first poll cannot precede it.
  - Timeout counting is unchanged and covers the poll cycles.
- Undefined: no STATUS reads are ever issued; completion comes only from the status_valid sideband.

Test Plan:
- Reset: assert rst mid-WR_CTRL -> cs/rd/wr=0 in the same cycle; busy=0, done=0, g_out=0, timeout_err=0.
- Happy path: behavioural slave returns G_out=50. Drive start with T=32, dT=32, reg_mode=1, dt_mode=0 ->
  - writes (02,32), (03,32), (01,8'h03) in cycles 1/3/5;
  - read of 04;
  - g_out=50, done pulses exactly once;
  - busy high for cycles 1–9.
- Internal dT: dt_mode=1 -> no write to 03 occurs; CTRL write data = 8'h05; sequence otherwise identical, 2 cycles shorter.
- Timeout: slave never pulses status_valid, TIMEOUT_CYC=20 -> done pulses 20 cycles after the CTRL write; timeout_err=1; g_out keeps its prior value; the next start clears timeout_err.
- Busy/back-to-back:
  - start pulsed during WAIT_DONE -> ignored: exactly one CTRL write;
  - start in the done cycle -> new T write in the following cycle.
- With FUZZY_MMIO_HOST_POLL_EN: slave busy held for 6 cycles -> STATUS reads repeat until bit0=0 is seen, then G_out is read; status_valid toggling is ignored.
